// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: default pixel width, pool window size,
// FSM state encoding and a counter-width helper.
package cnn_pkg;

  localparam int BITS       = 16;
  localparam int POOL_ELEMS = 4;

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    EMIT   = 1'b1
  } state_e;

  // Smallest counter width able to index n entries, never less than 1 bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-row pixel store: one synchronous write port, one combinational read
// port, no reset (contents are don't-care until written).
module line_buffer #(
  parameter int bits  = 16,
  parameter int depth = 8,
  parameter int aw    = 3
) (
  input  logic            clk_in,
  input  logic            we_i,
  input  logic [aw-1:0]   waddr_i,
  input  logic [bits-1:0] wdata_i,
  input  logic [aw-1:0]   raddr_i,
  output logic [bits-1:0] rdata_o
);

  logic [bits-1:0] mem [depth];

  always_ff @(posedge clk_in) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/pool_window_gather.sv
// Re-orders a row-major feature map into non-overlapping 2x2 windows, emitted
// as four consecutive samples for the serial max-pool stage.
module pool_window_gather
  import cnn_pkg::*;
#(
  parameter int bits       = BITS,
  parameter int img_width  = 8,
  parameter int img_height = 8
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [bits-1:0] data_in,
  input  logic            valid_in,
  output logic            ready_in,
  output logic [bits-1:0] win_data,
  output logic            win_start,
  output logic            win_valid,
  output logic            frame_done
);

  localparam int CW = clog2(img_width);
  localparam int RW = clog2(img_height);
  localparam int KW = clog2(POOL_ELEMS);
  localparam logic [CW-1:0] COL_LAST = CW'(img_width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(img_height - 1);

  if ((img_width % 2) != 0 || img_width < 2) begin : gWidthCheck
    $error("pool_window_gather: img_width must be even and >= 2");
  end
  if ((img_height % 2) != 0 || img_height < 2) begin : gHeightCheck
    $error("pool_window_gather: img_height must be even and >= 2");
  end

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   col_q, col_d, winCol_q, winCol_d;
  logic [RW-1:0]   row_q, row_d;
  logic            lastWin_q, lastWin_d;
  logic [bits-1:0] bl_q, bl_d, br_q, br_d;
  logic            rdy_q;
  logic [bits-1:0] winData_q, winData_d;
  logic            winStart_q, winStart_d, winValid_q, winValid_d;
  logic            frameDone_q, frameDone_d;
  logic            lbWe, accept;
  logic [CW-1:0]   lbRaddr;
  logic [bits-1:0] lbRdata;

  // Top-left is read during the completing accept, top-right one cycle later.
  assign lbRaddr = (state_q == EMIT) ? winCol_q : (col_q - CW'(1));

  line_buffer #(.bits(bits), .depth(img_width), .aw(CW)) u_lineBuffer (
    .clk_in  (clk_in),
    .we_i    (lbWe),
    .waddr_i (col_q),
    .wdata_i (data_in),
    .raddr_i (lbRaddr),
    .rdata_o (lbRdata)
  );

  assign ready_in = rdy_q && (state_q == ACCEPT);
  assign accept   = valid_in && ready_in;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    col_d       = col_q;
    row_d       = row_q;
    winCol_d    = winCol_q;
    lastWin_d   = lastWin_q;
    bl_d        = bl_q;
    br_d        = br_q;
    lbWe        = 1'b0;
    winData_d   = '0;
    winStart_d  = 1'b0;
    winValid_d  = 1'b0;
    frameDone_d = 1'b0;
    if (clear) begin
      state_d = ACCEPT;
      k_d     = '0;
      col_d   = '0;
      row_d   = '0;
    end else if (state_q == ACCEPT) begin
      if (accept) begin
        col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
        if (col_q == COL_LAST) row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        if (!row_q[0]) begin
          lbWe = 1'b1;
        end else if (!col_q[0]) begin
          bl_d = data_in;
        end else begin
          br_d       = data_in;
          winCol_d   = col_q;
          lastWin_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
          state_d    = EMIT;
          k_d        = '0;
          winData_d  = lbRdata;
          winStart_d = 1'b1;
          winValid_d = 1'b1;
        end
      end
    end else begin
      // k_q names the element currently on the outputs; load the following one.
      unique case (k_q)
        KW'(0): begin
          winData_d  = lbRdata;
          winValid_d = 1'b1;
          k_d        = KW'(1);
        end
        KW'(1): begin
          winData_d  = bl_q;
          winValid_d = 1'b1;
          k_d        = KW'(2);
        end
        KW'(2): begin
          winData_d   = br_q;
          winValid_d  = 1'b1;
          frameDone_d = lastWin_q;
          k_d         = KW'(3);
        end
        default: begin
          state_d = ACCEPT;
          k_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCEPT;
      k_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      winCol_q    <= '0;
      lastWin_q   <= 1'b0;
      bl_q        <= '0;
      br_q        <= '0;
      rdy_q       <= 1'b0;
      winData_q   <= '0;
      winStart_q  <= 1'b0;
      winValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      col_q       <= col_d;
      row_q       <= row_d;
      winCol_q    <= winCol_d;
      lastWin_q   <= lastWin_d;
      bl_q        <= bl_d;
      br_q        <= br_d;
      rdy_q       <= 1'b1;
      winData_q   <= winData_d;
      winStart_q  <= winStart_d;
      winValid_q  <= winValid_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign win_data   = winData_q;
  assign win_start  = winStart_q;
  assign win_valid  = winValid_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_pool_window_gather.sv
// Directed bench: a 4x4 instance for ordering/timing/clear/reset scenarios and
// an 8x8 instance fed with input gaps and chained into a max-pool model.
module tb_pool_window_gather;
  import cnn_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        clear4 = 1'b0, clear8 = 1'b0;
  logic [15:0] data4 = '0, data8 = '0;
  logic        valid4 = 1'b0, valid8 = 1'b0;
  logic        ready4, ready8;
  logic [15:0] winData4, winData8;
  logic        winStart4, winStart8, winValid4, winValid8, frameDone4, frameDone8;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct packed {
    logic        s;
    logic        d;
    logic [15:0] v;
  } samp_t;

  samp_t       q4[$], q8[$];
  logic [15:0] poolOut[$];
  logic [15:0] poolMax = '0;
  int          poolCnt = 0;
  int          stray4 = 0;
  logic [15:0] pix[$];
  logic [15:0] expv[$];

  pool_window_gather #(.bits(16), .img_width(4), .img_height(4)) dut4 (
    .clk_in(clk_in), .rst_n(rst_n), .clear(clear4), .data_in(data4), .valid_in(valid4),
    .ready_in(ready4), .win_data(winData4), .win_start(winStart4), .win_valid(winValid4),
    .frame_done(frameDone4)
  );

  pool_window_gather #(.bits(16), .img_width(8), .img_height(8)) dut8 (
    .clk_in(clk_in), .rst_n(rst_n), .clear(clear8), .data_in(data8), .valid_in(valid8),
    .ready_in(ready8), .win_data(winData8), .win_start(winStart8), .win_valid(winValid8),
    .frame_done(frameDone8)
  );

  always #5 clk_in = ~clk_in;

  // Output monitors, plus a serial max-pool model chained onto the 8x8 instance.
  always @(negedge clk_in) begin
    if (winValid4) q4.push_back({winStart4, frameDone4, winData4});
    else if (winStart4 || frameDone4) stray4++;
    if (winValid8) begin
      q8.push_back({winStart8, frameDone8, winData8});
      if (winStart8) begin
        poolMax = winData8;
        poolCnt = 1;
      end else begin
        if (winData8 > poolMax) poolMax = winData8;
        poolCnt++;
      end
      if (poolCnt == POOL_ELEMS) begin
        poolOut.push_back(poolMax);
        poolCnt = 0;
      end
    end
  end

  // Reference window order: each 2x2 block row-major, TL TR BL BR.
  function automatic void buildExpected(input int h, input int w);
    expv.delete();
    for (int r = 0; r < h; r += 2)
      for (int c = 0; c < w; c += 2) begin
        expv.push_back(pix[r*w + c]);
        expv.push_back(pix[r*w + c + 1]);
        expv.push_back(pix[(r+1)*w + c]);
        expv.push_back(pix[(r+1)*w + c + 1]);
      end
  endfunction

  // Present one pixel from a negedge, wait for ready, return at the negedge after acceptance.
  task automatic sendPixel(input bit sel, input logic [15:0] v);
    int n = 0;
    if (sel) begin data8 = v; valid8 = 1'b1; end
    else begin data4 = v; valid4 = 1'b1; end
    while (((sel ? ready8 : ready4) !== 1'b1) && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 50) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL accept_timeout: pixel %0d not accepted within %0d cycles, required acceptance", v, n);
    end
    @(posedge clk_in);
    @(negedge clk_in);
    valid4 = 1'b0;
    valid8 = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    assertCount++;
    if ({ready4, winValid4, winStart4, frameDone4, winData4} !== 20'h0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got rdy=%b v=%b s=%b d=%b data=%0d, required all 0",
               ready4, winValid4, winStart4, frameDone4, winData4);
    end
    rst_n = 1'b1;
    @(negedge clk_in);
    assertCount++;
    if (ready4 !== 1'b1 || ready8 !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_ready: got ready4=%b ready8=%b, required 1 1", ready4, ready8);
    end
  endtask

  task automatic test_frame4x4();
    q4.delete();
    pix.delete();
    for (int i = 1; i <= 16; i++) pix.push_back(16'(i));
    buildExpected(4, 4);
    for (int i = 0; i < 16; i++) sendPixel(1'b0, pix[i]);
    drain();
    assertCount++;
    if (q4.size() != 16) begin
      failCount++;
      $display("[TB] FAIL frame4_count: got %0d samples, required 16", q4.size());
    end
    for (int i = 0; i < 16 && i < q4.size(); i++) begin
      assertCount++;
      if (q4[i].v !== expv[i] || q4[i].s !== 1'(i % 4 == 0) || q4[i].d !== 1'(i == 15)) begin
        failCount++;
        $display("[TB] FAIL frame4_sample%0d: got v=%0d s=%b d=%b, required v=%0d s=%b d=%b",
                 i, q4[i].v, q4[i].s, q4[i].d, expv[i], 1'(i % 4 == 0), 1'(i == 15));
      end
    end
  endtask

  task automatic test_window_timing();
    logic [15:0] firstWin [4];
    firstWin = '{16'd51, 16'd52, 16'd55, 16'd56};
    q4.delete();
    pix.delete();
    for (int i = 51; i <= 66; i++) pix.push_back(16'(i));
    buildExpected(4, 4);
    for (int i = 0; i < 5; i++) sendPixel(1'b0, pix[i]);
    data4 = pix[5];
    valid4 = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    data4 = pix[6];
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (winValid4 !== 1'b1 || ready4 !== 1'b0 || winStart4 !== 1'(i == 0) || winData4 !== firstWin[i]) begin
        failCount++;
        $display("[TB] FAIL timing_t+%0d: got v=%b rdy=%b s=%b data=%0d, required v=1 rdy=0 s=%b data=%0d",
                 i + 1, winValid4, ready4, winStart4, winData4, 1'(i == 0), firstWin[i]);
      end
      @(negedge clk_in);
    end
    assertCount++;
    if (ready4 !== 1'b1 || winValid4 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL timing_t+5: got rdy=%b v=%b, required rdy=1 v=0", ready4, winValid4);
    end
    @(posedge clk_in);
    @(negedge clk_in);
    valid4 = 1'b0;
    for (int i = 7; i < 16; i++) sendPixel(1'b0, pix[i]);
    drain();
    assertCount++;
    if (q4.size() != 16) begin
      failCount++;
      $display("[TB] FAIL timing_count: got %0d samples, required 16", q4.size());
    end
    for (int i = 0; i < 16 && i < q4.size(); i++) begin
      assertCount++;
      if (q4[i].v !== expv[i]) begin
        failCount++;
        $display("[TB] FAIL timing_sample%0d: got %0d, required %0d", i, q4[i].v, expv[i]);
      end
    end
  endtask

  task automatic test_gaps8x8();
    logic [15:0] m;
    q8.delete();
    poolOut.delete();
    pix.delete();
    for (int i = 0; i < 64; i++) pix.push_back(16'($urandom_range(0, 65535)));
    buildExpected(8, 8);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 1) == 1) @(negedge clk_in);
      sendPixel(1'b1, pix[i]);
    end
    drain();
    assertCount++;
    if (q8.size() != 64 || poolOut.size() != 16) begin
      failCount++;
      $display("[TB] FAIL gaps_count: got %0d samples %0d pool results, required 64 16", q8.size(), poolOut.size());
    end
    for (int i = 0; i < 64 && i < q8.size(); i++) begin
      assertCount++;
      if (q8[i].v !== expv[i] || q8[i].s !== 1'(i % 4 == 0) || q8[i].d !== 1'(i == 63)) begin
        failCount++;
        $display("[TB] FAIL gaps_sample%0d: got v=%0d s=%b d=%b, required v=%0d s=%b d=%b",
                 i, q8[i].v, q8[i].s, q8[i].d, expv[i], 1'(i % 4 == 0), 1'(i == 63));
      end
    end
    for (int w = 0; w < 16 && w < poolOut.size(); w++) begin
      m = expv[4*w];
      for (int j = 1; j < 4; j++) if (expv[4*w + j] > m) m = expv[4*w + j];
      assertCount++;
      if (poolOut[w] !== m) begin
        failCount++;
        $display("[TB] FAIL pool_max%0d: got %0d, required %0d", w, poolOut[w], m);
      end
    end
  endtask

  task automatic test_clear();
    logic [15:0] partial [6];
    partial = '{16'd1, 16'd2, 16'd5, 16'd6, 16'd3, 16'd4};
    q4.delete();
    for (int i = 1; i <= 8; i++) sendPixel(1'b0, 16'(i));
    @(negedge clk_in);
    clear4 = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    clear4 = 1'b0;
    assertCount++;
    if (winValid4 !== 1'b0 || ready4 !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL clear_abort: got v=%b rdy=%b, required v=0 rdy=1", winValid4, ready4);
    end
    pix.delete();
    for (int i = 101; i <= 116; i++) pix.push_back(16'(i));
    buildExpected(4, 4);
    for (int i = 0; i < 16; i++) sendPixel(1'b0, pix[i]);
    drain();
    assertCount++;
    if (q4.size() != 22) begin
      failCount++;
      $display("[TB] FAIL clear_count: got %0d samples, required 22", q4.size());
    end
    for (int i = 0; i < 6 && i < q4.size(); i++) begin
      assertCount++;
      if (q4[i].v !== partial[i] || q4[i].s !== 1'(i % 4 == 0) || q4[i].d !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL clear_pre%0d: got v=%0d s=%b d=%b, required v=%0d s=%b d=0",
                 i, q4[i].v, q4[i].s, q4[i].d, partial[i], 1'(i % 4 == 0));
      end
    end
    for (int i = 0; i < 16 && i + 6 < q4.size(); i++) begin
      assertCount++;
      if (q4[i+6].v !== expv[i] || q4[i+6].s !== 1'(i % 4 == 0) || q4[i+6].d !== 1'(i == 15)) begin
        failCount++;
        $display("[TB] FAIL clear_post%0d: got v=%0d s=%b d=%b, required v=%0d s=%b d=%b",
                 i, q4[i+6].v, q4[i+6].s, q4[i+6].d, expv[i], 1'(i % 4 == 0), 1'(i == 15));
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 6; i++) sendPixel(1'b0, 16'(i + 200));
    #2;
    rst_n = 1'b0;
    #1;
    assertCount++;
    if ({ready4, winValid4, winStart4, frameDone4, winData4} !== 20'h0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got rdy=%b v=%b s=%b d=%b data=%0d, required all 0",
               ready4, winValid4, winStart4, frameDone4, winData4);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    q4.delete();
    pix.delete();
    for (int i = 221; i <= 236; i++) pix.push_back(16'(i));
    buildExpected(4, 4);
    for (int i = 0; i < 16; i++) sendPixel(1'b0, pix[i]);
    drain();
    assertCount++;
    if (q4.size() != 16) begin
      failCount++;
      $display("[TB] FAIL rst_frame_count: got %0d samples, required 16", q4.size());
    end
    for (int i = 0; i < 16 && i < q4.size(); i++) begin
      assertCount++;
      if (q4[i].v !== expv[i] || q4[i].s !== 1'(i % 4 == 0) || q4[i].d !== 1'(i == 15)) begin
        failCount++;
        $display("[TB] FAIL rst_frame_sample%0d: got v=%0d s=%b d=%b, required v=%0d",
                 i, q4[i].v, q4[i].s, q4[i].d, expv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp2[$];
    int doneCount;
    q4.delete();
    exp2.delete();
    for (int f = 0; f < 2; f++) begin
      pix.delete();
      for (int i = 1; i <= 16; i++) pix.push_back(16'(300 + 100*f + i));
      buildExpected(4, 4);
      foreach (expv[j]) exp2.push_back(expv[j]);
    end
    for (int f = 0; f < 2; f++)
      for (int i = 1; i <= 16; i++) sendPixel(1'b0, 16'(300 + 100*f + i));
    drain();
    doneCount = 0;
    foreach (q4[j]) if (q4[j].d) doneCount++;
    assertCount++;
    if (q4.size() != 32 || doneCount != 2) begin
      failCount++;
      $display("[TB] FAIL b2b_count: got %0d samples %0d frame_done, required 32 2", q4.size(), doneCount);
    end
    for (int i = 0; i < 32 && i < q4.size(); i++) begin
      assertCount++;
      if (q4[i].v !== exp2[i] || q4[i].s !== 1'(i % 4 == 0) || q4[i].d !== 1'(i % 16 == 15)) begin
        failCount++;
        $display("[TB] FAIL b2b_sample%0d: got v=%0d s=%b d=%b, required v=%0d s=%b d=%b",
                 i, q4[i].v, q4[i].s, q4[i].d, exp2[i], 1'(i % 4 == 0), 1'(i % 16 == 15));
      end
    end
    assertCount++;
    if (stray4 != 0) begin
      failCount++;
      $display("[TB] FAIL stray_pulses: got %0d start/done pulses without valid, required 0", stray4);
    end
  endtask

  initial begin
    test_reset();
    test_frame4x4();
    test_window_timing();
    test_gaps8x8();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
